// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared constants and helpers for the writeback arbiter
package wb_arb_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic {
    SRC_IP  = 1'b0,
    SRC_LSP = 1'b1
  } wb_src_e;

  // Writes aimed at x0 are architecturally dropped, so they only retire.
  function automatic logic is_write(input logic valid, input logic wb_en, input logic [4:0] dst);
    return valid && wb_en && (dst != REG_X0);
  endfunction

endpackage

// File: rtl/wb_arb.sv
// rtl/wb_arb.sv - writeback arbiter for the single register-file write port
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ip_wb_dst,
  input  logic [63:0] ip_wb_result,
  input  logic [63:0] ip_wb_pc,
  input  logic        ip_wb_wb_en,
  input  logic        ip_wb_valid,
  output logic        ip_wb_ready,
  input  logic [4:0]  lsp_wb_dst,
  input  logic [63:0] lsp_wb_result,
  input  logic [63:0] lsp_wb_pc,
  input  logic        lsp_wb_wb_en,
  input  logic        lsp_wb_valid,
  output logic        lsp_wb_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_wdst,
  output logic [63:0] rf_wdata,
  output logic [63:0] retire_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       ip_req, lsp_req, contended;
  logic       grant_ip, grant_lsp;
  logic       ip_acc, lsp_acc;
  logic       unused_pc;

  assign unused_pc = ^{ip_wb_pc, lsp_wb_pc};

  always_comb begin
    ip_req    = is_write(ip_wb_valid, ip_wb_wb_en, ip_wb_dst);
    lsp_req   = is_write(lsp_wb_valid, lsp_wb_wb_en, lsp_wb_dst);
    contended = ip_req && lsp_req;
    grant_lsp = lsp_req && (!ip_req || (starve_cnt < LIMIT));
    grant_ip  = ip_req && !grant_lsp;
    // Retire-only entries bypass the write port and are always accepted.
    ip_wb_ready  = !rst && ((ip_wb_valid && !ip_req) || grant_ip);
    lsp_wb_ready = !rst && ((lsp_wb_valid && !lsp_req) || grant_lsp);
    ip_acc  = ip_wb_valid && ip_wb_ready;
    lsp_acc = lsp_wb_valid && lsp_wb_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (contended && grant_lsp) begin
      if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
    end else if (grant_ip || !ip_wb_valid) begin
      starve_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_wdst  <= 5'd0;
      rf_wdata <= 64'd0;
    end else begin
      rf_wen <= grant_ip || grant_lsp;
      if (grant_lsp) begin
        rf_wdst  <= lsp_wb_dst;
        rf_wdata <= lsp_wb_result;
      end else if (grant_ip) begin
        rf_wdst  <= ip_wb_dst;
        rf_wdata <= ip_wb_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) retire_cnt <= 64'd0;
    else     retire_cnt <= retire_cnt + 64'(ip_acc) + 64'(lsp_acc);
  end

`ifdef VERBOSE
  always_ff @(posedge clk) begin
    if (ip_acc)
      $display("wb_arb: pc=%h dst=%0d data=%h src=%s", ip_wb_pc, ip_wb_dst, ip_wb_result, SRC_IP.name());
    if (lsp_acc)
      $display("wb_arb: pc=%h dst=%0d data=%h src=%s", lsp_wb_pc, lsp_wb_dst, lsp_wb_result, SRC_LSP.name());
  end
`endif

endmodule

// File: tb/tb_wb_arb.sv
// tb/tb_wb_arb.sv - directed self-checking bench for wb_arb
module tb_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ip_wb_dst, lsp_wb_dst;
  logic [63:0] ip_wb_result, ip_wb_pc, lsp_wb_result, lsp_wb_pc;
  logic        ip_wb_wb_en, ip_wb_valid, ip_wb_ready;
  logic        lsp_wb_wb_en, lsp_wb_valid, lsp_wb_ready;
  logic        rf_wen;
  logic [4:0]  rf_wdst;
  logic [63:0] rf_wdata, retire_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arb #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .ip_wb_dst(ip_wb_dst), .ip_wb_result(ip_wb_result), .ip_wb_pc(ip_wb_pc),
    .ip_wb_wb_en(ip_wb_wb_en), .ip_wb_valid(ip_wb_valid), .ip_wb_ready(ip_wb_ready),
    .lsp_wb_dst(lsp_wb_dst), .lsp_wb_result(lsp_wb_result), .lsp_wb_pc(lsp_wb_pc),
    .lsp_wb_wb_en(lsp_wb_wb_en), .lsp_wb_valid(lsp_wb_valid), .lsp_wb_ready(lsp_wb_ready),
    .rf_wen(rf_wen), .rf_wdst(rf_wdst), .rf_wdata(rf_wdata), .retire_cnt(retire_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ip(input logic v, input logic en, input logic [4:0] d, input logic [63:0] r);
    ip_wb_valid = v; ip_wb_wb_en = en; ip_wb_dst = d; ip_wb_result = r; ip_wb_pc = 64'h1000 + 64'(d);
  endtask

  task automatic set_lsp(input logic v, input logic en, input logic [4:0] d, input logic [63:0] r);
    lsp_wb_valid = v; lsp_wb_wb_en = en; lsp_wb_dst = d; lsp_wb_result = r; lsp_wb_pc = 64'h2000 + 64'(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic readies(input string tag, input logic exp_ip, input logic exp_lsp);
    #1;
    check({tag, " ip_ready"}, 64'(ip_wb_ready), 64'(exp_ip));
    check({tag, " lsp_ready"}, 64'(lsp_wb_ready), 64'(exp_lsp));
  endtask

  initial begin
    rst = 1'b1;
    set_ip(1'b0, 1'b0, 5'd0, 64'd0);
    set_lsp(1'b0, 1'b0, 5'd0, 64'd0);
    step(); step();
    rst = 1'b0;
    check("reset rf_wen", 64'(rf_wen), 64'd0);
    check("reset rf_wdst", 64'(rf_wdst), 64'd0);
    check("reset rf_wdata", rf_wdata, 64'd0);
    check("reset retire_cnt", retire_cnt, 64'd0);
    check("reset starve_cnt", 64'(dut.starve_cnt), 64'd0);

    // IP alone, four back-to-back writes
    set_ip(1'b1, 1'b1, 5'd5, 64'hDEAD);
    for (int i = 0; i < 4; i++) begin
      readies("ip_only", 1'b1, 1'b0);
      step();
      check("ip_only rf_wen", 64'(rf_wen), 64'd1);
      check("ip_only rf_wdst", 64'(rf_wdst), 64'd5);
      check("ip_only rf_wdata", rf_wdata, 64'hDEAD);
      check("ip_only retire_cnt", retire_cnt, 64'(i + 1));
    end
    set_ip(1'b0, 1'b0, 5'd0, 64'd0);
    step();
    check("idle rf_wen", 64'(rf_wen), 64'd0);
    check("idle rf_wdst hold", 64'(rf_wdst), 64'd5);
    check("idle rf_wdata hold", rf_wdata, 64'hDEAD);
    check("idle retire_cnt", retire_cnt, 64'd4);

    // Continuous contention: LSP,LSP,LSP,IP repeating
    set_ip(1'b1, 1'b1, 5'd3, 64'h1111);
    set_lsp(1'b1, 1'b1, 5'd4, 64'h2222);
    for (int k = 0; k < 8; k++) begin
      readies("contend", (k % 4) == 3, (k % 4) != 3);
      step();
      check("contend rf_wen", 64'(rf_wen), 64'd1);
      check("contend rf_wdst", 64'(rf_wdst), ((k % 4) == 3) ? 64'd3 : 64'd4);
      check("contend rf_wdata", rf_wdata, ((k % 4) == 3) ? 64'h1111 : 64'h2222);
      check("contend starve_cnt", 64'(dut.starve_cnt), ((k % 4) == 3) ? 64'd0 : 64'((k % 4) + 1));
    end
    check("contend retire_cnt", retire_cnt, 64'd12);

    // IP writes x0 (retire-only) alongside an LSP write to x7
    set_ip(1'b1, 1'b1, 5'd0, 64'hBAD);
    set_lsp(1'b1, 1'b1, 5'd7, 64'h7777);
    readies("x0", 1'b1, 1'b1);
    step();
    check("x0 rf_wen", 64'(rf_wen), 64'd1);
    check("x0 rf_wdst", 64'(rf_wdst), 64'd7);
    check("x0 rf_wdata", rf_wdata, 64'h7777);
    check("x0 retire_cnt", retire_cnt, 64'd14);

    // Both retire-only
    set_ip(1'b1, 1'b0, 5'd9, 64'h9);
    set_lsp(1'b1, 1'b0, 5'd10, 64'hA);
    for (int i = 0; i < 2; i++) begin
      readies("retire_only", 1'b1, 1'b1);
      step();
      check("retire_only rf_wen", 64'(rf_wen), 64'd0);
      check("retire_only rf_wdst hold", 64'(rf_wdst), 64'd7);
      check("retire_only retire_cnt", retire_cnt, 64'(16 + 2 * i));
    end

    // Reset in the middle of contention
    set_ip(1'b1, 1'b1, 5'd3, 64'h1111);
    set_lsp(1'b1, 1'b1, 5'd4, 64'h2222);
    step();
    check("pre_rst starve_cnt", 64'(dut.starve_cnt), 64'd1);
    check("pre_rst retire_cnt", retire_cnt, 64'd19);
    rst = 1'b1;
    readies("in_rst", 1'b0, 1'b0);
    step();
    rst = 1'b0;
    check("post_rst rf_wen", 64'(rf_wen), 64'd0);
    check("post_rst rf_wdst", 64'(rf_wdst), 64'd0);
    check("post_rst rf_wdata", rf_wdata, 64'd0);
    check("post_rst retire_cnt", retire_cnt, 64'd0);
    check("post_rst starve_cnt", 64'(dut.starve_cnt), 64'd0);
    readies("resume", 1'b0, 1'b1);
    step();
    check("resume rf_wen", 64'(rf_wen), 64'd1);
    check("resume rf_wdst", 64'(rf_wdst), 64'd4);
    check("resume starve_cnt", 64'(dut.starve_cnt), 64'd1);
    check("resume retire_cnt", retire_cnt, 64'd1);

    // Second contended loss, then IP drops valid for one cycle
    readies("wait2", 1'b0, 1'b1);
    step();
    check("wait2 starve_cnt", 64'(dut.starve_cnt), 64'd2);
    set_ip(1'b0, 1'b1, 5'd3, 64'h1111);
    readies("gap", 1'b0, 1'b1);
    step();
    check("gap starve_cnt", 64'(dut.starve_cnt), 64'd0);
    check("gap retire_cnt", retire_cnt, 64'd3);
    set_ip(1'b1, 1'b1, 5'd3, 64'h1111);
    for (int k = 0; k < 4; k++) begin
      readies("restart", k == 3, k != 3);
      step();
      check("restart rf_wdst", 64'(rf_wdst), (k == 3) ? 64'd3 : 64'd4);
    end
    check("restart starve_cnt", 64'(dut.starve_cnt), 64'd0);
    check("restart retire_cnt", retire_cnt, 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
